// File: rtl/cme_cpu_pkg.sv
// Shared definitions for the CME CPU core: sequencer state encoding, address widths,
// reset vector and from_PS debug field positions.
package cme_cpu_pkg;

  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned NIBBLE_W    = 4;
  localparam int unsigned STACK_DEPTH = 4;
  localparam int unsigned PTR_W       = 3;

  localparam logic [ADDR_W-1:0] RESET_VECTOR = 8'h00;

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_FETCH0 = 2'd1,
    S_RUN    = 2'd2,
    S_HOLD   = 2'd3
  } ps_state_t;

  // from_PS = {state[1:0], taken, stk_ptr[2:0], ovf, udf}
  localparam int unsigned PS_STATE_LSB = 6;
  localparam int unsigned PS_TAKEN_BIT = 5;
  localparam int unsigned PS_PTR_LSB   = 2;
  localparam int unsigned PS_OVF_BIT   = 1;
  localparam int unsigned PS_UDF_BIT   = 0;

endpackage

// File: rtl/ps_return_stack.sv
// Return-address LIFO for the program sequencer. Pushes when full and pops when empty are
// ignored; the caller tracks overflow/underflow.
module ps_return_stack #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8,
  parameter int unsigned PtrW  = 3
) (
  input  logic             clk,
  input  logic             sync_reset,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] push_data,
  output logic [Width-1:0] top_data,
  output logic             full,
  output logic             empty,
  output logic [PtrW-1:0]  ptr
);

  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  ptr_q;
  logic [IdxW-1:0]  wr_idx;
  logic [IdxW-1:0]  top_idx;

  assign full     = (ptr_q == PtrW'(Depth));
  assign empty    = (ptr_q == '0);
  assign wr_idx   = IdxW'(ptr_q);
  assign top_idx  = IdxW'(ptr_q - PtrW'(1));
  assign top_data = mem_q[top_idx];
  assign ptr      = ptr_q;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      ptr_q <= '0;
    end else if (pop && !empty) begin
      ptr_q <= ptr_q - PtrW'(1);
    end else if (push && !full) begin
      mem_q[wr_idx] <= push_data;
      ptr_q         <= ptr_q + PtrW'(1);
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// Program-memory address sequencer: reset/fetch/run/hold FSM with jump, conditional jump and,
// when PS_CALL_STACK_EN is defined, a call/return stack with sticky overflow/underflow flags.
module program_sequencer
  import cme_cpu_pkg::*;
(
  input  logic                clk,
  input  logic                sync_reset,
  input  logic                jump,
  input  logic                conditional_jump,
  input  logic                zero_flag,
  input  logic                hold,
  input  logic [NIBBLE_W-1:0] LS_nibble_of_ir,
  input  logic                call,
  input  logic                ret,
  output logic [ADDR_W-1:0]   pm_address,
  output logic [ADDR_W-1:0]   pc,
  output logic [7:0]          from_PS
);

  ps_state_t         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc, target;
  logic [ADDR_W-1:0] jmp_addr;
  logic              jmp_taken;
  logic              taken;
  logic [PTR_W-1:0]  stk_ptr;
  logic              stk_ovf, stk_udf;

  assign pc     = pc_q;
  assign pc_inc = pc_q + ADDR_W'(1);
  assign target = {pc_q[ADDR_W-1:NIBBLE_W], LS_nibble_of_ir};

  // Unconditional jump outranks the conditional one when both are asserted.
  always_comb begin
    jmp_addr  = pc_inc;
    jmp_taken = 1'b0;
    if (jump || (conditional_jump && !zero_flag)) begin
      jmp_addr  = target;
      jmp_taken = 1'b1;
    end
  end

`ifdef PS_CALL_STACK_EN
  logic              push, pop, stk_full, stk_empty, ovf_set, udf_set;
  logic [ADDR_W-1:0] stk_top;

  ps_return_stack #(
    .Depth (STACK_DEPTH),
    .Width (ADDR_W),
    .PtrW  (PTR_W)
  ) u_stack (
    .clk        (clk),
    .sync_reset (sync_reset),
    .push       (push),
    .pop        (pop),
    .push_data  (pc_inc),
    .top_data   (stk_top),
    .full       (stk_full),
    .empty      (stk_empty),
    .ptr        (stk_ptr)
  );

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      stk_ovf <= 1'b0;
      stk_udf <= 1'b0;
    end else begin
      stk_ovf <= stk_ovf | ovf_set;
      stk_udf <= stk_udf | udf_set;
    end
  end
`else
  logic unused_ctl;
  assign unused_ctl = call ^ ret;
  assign stk_ptr    = '0;
  assign stk_ovf    = 1'b0;
  assign stk_udf    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pm_address = pc_q;
    taken      = 1'b0;
`ifdef PS_CALL_STACK_EN
    push       = 1'b0;
    pop        = 1'b0;
    ovf_set    = 1'b0;
    udf_set    = 1'b0;
`endif
    if (sync_reset) begin
      pm_address = RESET_VECTOR;
      state_d    = S_RESET;
    end else begin
      case (state_q)
        S_RESET: begin
          pm_address = RESET_VECTOR;
          state_d    = S_FETCH0;
        end
        S_FETCH0: begin
          pm_address = RESET_VECTOR;
          pc_d       = RESET_VECTOR;
          state_d    = S_RUN;
        end
        S_RUN: begin
          if (hold) begin
            state_d = S_HOLD;
          end else begin
`ifdef PS_CALL_STACK_EN
            if (ret) begin
              if (stk_empty) begin
                pm_address = pc_inc;
                udf_set    = 1'b1;
              end else begin
                pm_address = stk_top;
                taken      = 1'b1;
                pop        = 1'b1;
              end
            end else if (call) begin
              pm_address = target;
              taken      = 1'b1;
              push       = !stk_full;
              ovf_set    = stk_full;
            end else begin
              pm_address = jmp_addr;
              taken      = jmp_taken;
            end
`else
            pm_address = jmp_addr;
            taken      = jmp_taken;
`endif
            pc_d = pm_address;
          end
        end
        S_HOLD: begin
          if (!hold) state_d = S_RUN;
        end
        default: state_d = S_RESET;
      endcase
    end

    from_PS = '0;
    from_PS[PS_STATE_LSB +: 2]     = state_q;
    from_PS[PS_TAKEN_BIT]          = taken;
    from_PS[PS_PTR_LSB +: PTR_W]   = stk_ptr;
    from_PS[PS_OVF_BIT]            = stk_ovf;
    from_PS[PS_UDF_BIT]            = stk_udf;
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state_q <= S_RESET;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: directed vector table, hand-written corner sequences and a
// random sweep checked against a behavioural address-stream model.
module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       sync_reset, jump, conditional_jump, zero_flag, hold, call, ret;
  logic [3:0] LS_nibble_of_ir;
  logic [7:0] pm_address, pc, from_PS;

  int n_err = 0;
  int n_chk = 0;

  program_sequencer dut (
    .clk              (clk),
    .sync_reset       (sync_reset),
    .jump             (jump),
    .conditional_jump (conditional_jump),
    .zero_flag        (zero_flag),
    .hold             (hold),
    .LS_nibble_of_ir  (LS_nibble_of_ir),
    .call             (call),
    .ret              (ret),
    .pm_address       (pm_address),
    .pc               (pc),
    .from_PS          (from_PS)
  );

  always #5 clk = ~clk;

  // Model: cycles since reset release, a stalled flag, pc and a queue as the return stack.
  int         m_age   = 0;
  bit         m_stall = 1'b0;
  bit         m_known = 1'b0;
  logic [7:0] m_pc    = 8'h00;
  logic [7:0] m_stk[$];
  bit         m_ovf   = 1'b0;
  bit         m_udf   = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit j, input bit cj, input bit zf, input bit hd,
                      input logic [3:0] nib, input bit cl, input bit rt,
                      output logic [7:0] g_pm, output logic [7:0] g_pc,
                      output logic [7:0] g_ps);
    logic [7:0] e_pm, tgt, inc;
    bit         e_tk, do_push, do_pop, set_ovf, set_udf;
    logic [1:0] e_st;
    logic [2:0] e_ptr;
    sync_reset = rst; jump = j; conditional_jump = cj; zero_flag = zf; hold = hd;
    LS_nibble_of_ir = nib; call = cl; ret = rt;
    tgt = {m_pc[7:4], nib};
    inc = m_pc + 8'd1;
    e_tk = 1'b0; do_push = 1'b0; do_pop = 1'b0; set_ovf = 1'b0; set_udf = 1'b0;
    if (rst)                    e_pm = 8'h00;
    else if (m_age < 2)         e_pm = 8'h00;
    else if (m_stall || hd)     e_pm = m_pc;
    else begin
`ifdef PS_CALL_STACK_EN
      if (rt) begin
        if (m_stk.size() > 0) begin e_pm = m_stk[$]; e_tk = 1'b1; do_pop = 1'b1; end
        else begin e_pm = inc; set_udf = 1'b1; end
      end else if (cl) begin
        e_pm = tgt; e_tk = 1'b1;
        if (m_stk.size() < 4) do_push = 1'b1; else set_ovf = 1'b1;
      end else
`endif
      if (j || (cj && !zf)) begin e_pm = tgt; e_tk = 1'b1; end
      else e_pm = inc;
    end
    e_st  = (m_age == 0) ? 2'd0 : (m_age == 1) ? 2'd1 : (m_stall ? 2'd3 : 2'd2);
    e_ptr = 3'(m_stk.size());
    @(negedge clk);
    g_pm = pm_address; g_pc = pc; g_ps = from_PS;
    chk("model_pm_address", g_pm, e_pm);
    if (m_known) begin
      chk("model_pc", g_pc, m_pc);
      chk("model_from_PS", g_ps, {e_st, e_tk, e_ptr, m_ovf, m_udf});
    end
    @(posedge clk);
    if (rst) begin
      m_age = 0; m_stall = 1'b0; m_pc = 8'h00; m_stk.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_known = 1'b1;
    end else if (m_age == 0) m_age = 1;
    else if (m_age == 1) begin m_age = 2; m_pc = 8'h00; end
    else if (m_stall) m_stall = hd;
    else if (hd) m_stall = 1'b1;
    else begin
      m_pc = e_pm;
      if (do_push) m_stk.push_back(inc);
      if (do_pop) void'(m_stk.pop_back());
      m_ovf = m_ovf | set_ovf;
      m_udf = m_udf | set_udf;
    end
    #1;
  endtask

  logic [7:0] g_pm, g_pc, g_ps;

  task automatic idle();
    step(0, 0, 0, 0, 0, 4'h0, 0, 0, g_pm, g_pc, g_ps);
  endtask

  // Reset, then run sequentially so the next step sees pc == tgt.
  task automatic reset_to(input int tgt);
    step(1, 0, 0, 0, 0, 4'h0, 0, 0, g_pm, g_pc, g_ps);
    step(1, 0, 0, 0, 0, 4'h0, 0, 0, g_pm, g_pc, g_ps);
    for (int k = 0; k < tgt + 2; k++) idle();
  endtask

  typedef struct {
    bit         rst, j, cj, zf, hd;
    logic [3:0] nib;
    logic [7:0] pm, pc;
    bit         chk_pc;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 0, 4'h0, 8'h00, 8'h00, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 4'h0, 8'h00, 8'h00, 1};
    tbl[2]  = '{1, 0, 0, 0, 0, 4'h0, 8'h00, 8'h00, 1};
    tbl[3]  = '{0, 0, 0, 0, 0, 4'h0, 8'h00, 8'h00, 1};
    tbl[4]  = '{0, 1, 0, 0, 0, 4'h9, 8'h00, 8'h00, 1};
    tbl[5]  = '{0, 0, 0, 0, 0, 4'h0, 8'h01, 8'h00, 1};
    tbl[6]  = '{0, 0, 0, 0, 0, 4'h0, 8'h02, 8'h01, 1};
    tbl[7]  = '{0, 1, 0, 0, 0, 4'hC, 8'h0C, 8'h02, 1};
    tbl[8]  = '{0, 0, 1, 1, 0, 4'h3, 8'h0D, 8'h0C, 1};
    tbl[9]  = '{0, 0, 1, 0, 0, 4'h3, 8'h03, 8'h0D, 1};
    tbl[10] = '{0, 1, 1, 0, 0, 4'h8, 8'h08, 8'h03, 1};
    tbl[11] = '{0, 1, 0, 0, 1, 4'h1, 8'h08, 8'h08, 1};
    tbl[12] = '{0, 0, 0, 0, 0, 4'h0, 8'h08, 8'h08, 1};
    tbl[13] = '{0, 0, 0, 0, 0, 4'h0, 8'h09, 8'h08, 1};
    tbl[14] = '{1, 1, 0, 0, 0, 4'h4, 8'h00, 8'h09, 1};
    tbl[15] = '{0, 0, 0, 0, 0, 4'h0, 8'h00, 8'h00, 1};

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].rst, tbl[i].j, tbl[i].cj, tbl[i].zf, tbl[i].hd, tbl[i].nib, 0, 0,
           g_pm, g_pc, g_ps);
      chk($sformatf("tbl%0d_pm", i), g_pm, tbl[i].pm);
      if (tbl[i].chk_pc) chk($sformatf("tbl%0d_pc", i), g_pc, tbl[i].pc);
    end

    // Jump within page 0x3x
    reset_to(8'h35);
    step(0, 1, 0, 0, 0, 4'hA, 0, 0, g_pm, g_pc, g_ps);
    chk("jump_pm", g_pm, 8'h3A);
    chk("jump_taken", g_ps[5], 1'b1);
    idle();
    chk("jump_pc", g_pc, 8'h3A);

    // Conditional jump on zero flag, and jump+cond together
    reset_to(8'h40);
    step(0, 0, 1, 1, 0, 4'h7, 0, 0, g_pm, g_pc, g_ps);
    chk("cj_z1_pm", g_pm, 8'h41);
    chk("cj_z1_taken", g_ps[5], 1'b0);
    step(0, 0, 1, 0, 0, 4'h7, 0, 0, g_pm, g_pc, g_ps);
    chk("cj_z0_pm", g_pm, 8'h47);
    step(0, 1, 1, 1, 0, 4'h2, 0, 0, g_pm, g_pc, g_ps);
    chk("j_cj_pm", g_pm, 8'h42);

    // Wrap at 0xFF, then hold for two clocks with a jump that must be ignored
    reset_to(8'hFF);
    idle();
    chk("wrap_pm", g_pm, 8'h00);
    step(0, 0, 0, 0, 1, 4'h0, 0, 0, g_pm, g_pc, g_ps);
    chk("hold1_pc", g_pc, 8'h00);
    step(0, 1, 0, 0, 1, 4'h9, 0, 0, g_pm, g_pc, g_ps);
    chk("hold2_pm", g_pm, 8'h00);
    chk("hold2_state", g_ps[7:6], 2'd3);
    step(0, 0, 0, 0, 0, 4'h0, 0, 0, g_pm, g_pc, g_ps);
    chk("unhold_pm", g_pm, 8'h00);
    idle();
    chk("resume_pm", g_pm, 8'h01);

    // Reset wins over a jump mid-run
    reset_to(8'h5C);
    step(1, 1, 0, 0, 0, 4'h3, 0, 0, g_pm, g_pc, g_ps);
    chk("midrst_pm", g_pm, 8'h00);
    idle();
    chk("midrst_state", g_ps[7:6], 2'd0);
    chk("midrst_pc", g_pc, 8'h00);

`ifdef PS_CALL_STACK_EN
    reset_to(8'h10);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 4'h0, 1, 0, g_pm, g_pc, g_ps);
      chk($sformatf("call%0d_pm", i), g_pm, 8'h10);
    end
    chk("call5_ovf_pre", g_ps[1], 1'b0);
    chk("call5_ptr", g_ps[4:2], 3'd4);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 4'h0, 0, 1, g_pm, g_pc, g_ps);
      if (i == 0) chk("ovf_sticky", g_ps[1], 1'b1);
      chk($sformatf("ret%0d_pm", i), g_pm, (i < 4) ? 8'h11 : 8'h12);
    end
    idle();
    chk("udf_sticky", g_ps[0], 1'b1);
`endif

    // Random sweep against the model
    for (int i = 0; i < 2500; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), g_pm, g_pc, g_ps);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
